// File: rtl/int_ctrl.sv
// int_ctrl -- interrupt controller for the UR408 core.
//
// Four asynchronous interrupt pins are synchronised, latched (edge lines) or
// followed (level lines), masked, and prioritised (int0 highest). One request
// is presented to the core together with its 16-bit handler vector. A single,
// non-nested in-service level is tracked; ret closes it. New requests are held
// off while a bus transfer is outstanding.
//
// Ports:
//   clk         in   core clock, rising edge
//   rst         in   asynchronous, active-low reset
//   int0..int3  in   asynchronous interrupt pins, int0 highest priority
//   mem_read    in   bus read in progress
//   mem_write   in   bus write in progress
//   mem_ok      in   bus transfer completes this cycle
//   cfg_write   in   write cfg_wdata into {gie, mask[3:0]}
//   cfg_wdata   in   [4:0] {gie, mask[3:0]}, mask bit 1 = line enabled
//   cfg_data    out  [4:0] readback of {gie, mask[3:0]}
//   irq_req     out  request to core
//   irq_vector  out  [15:0] handler address, valid while irq_req=1
//   irq_ack     in   core has taken the vector (1-cycle pulse)
//   ret         in   return-from-interrupt executed (1-cycle pulse)
//   pending     out  [3:0] pending flags
//   in_service  out  a handler is active
//   isr_id      out  [1:0] id of the active or requested line
module int_ctrl #(
    parameter logic [15:0] VEC_BASE   = 16'h0004,
    parameter logic [15:0] VEC_STRIDE = 16'h0004,
    parameter logic [3:0]  EDGE_MASK  = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int0,
    input  logic        int1,
    input  logic        int2,
    input  logic        int3,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_ok,
    input  logic        cfg_write,
    input  logic [4:0]  cfg_wdata,
    output logic [4:0]  cfg_data,
    output logic        irq_req,
    output logic [15:0] irq_vector,
    input  logic        irq_ack,
    input  logic        ret,
    output logic [3:0]  pending,
    output logic        in_service,
    output logic [1:0]  isr_id
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  pins;
    logic [3:0]  sync1, sync2, sync3;
    logic [3:0]  edge_pend;
    logic [3:0]  pend_clr;
    logic [3:0]  mask, mask_nxt;
    logic [3:0]  elig;
    logic [1:0]  sel;
    logic        gie, gie_nxt;
    logic        gie_saved, gie_saved_nxt;
    logic        bus_busy;
    logic        req_nxt;
    logic        svc_nxt;
    logic [15:0] vec_nxt;
    logic [1:0]  id_nxt;

    // Lowest-index set bit wins.
    function automatic logic [1:0] prio_sel(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Vector arithmetic wraps modulo 2^16.
    function automatic logic [15:0] vec_of(input logic [1:0] id);
        logic [15:0] v;
        v = VEC_BASE + VEC_STRIDE * {14'd0, id};
        return v;
    endfunction

    assign pins     = {int3, int2, int1, int0};
    // Edge lines report the latched flag; level lines follow the synchronised pin.
    assign pending  = (EDGE_MASK & edge_pend) | (~EDGE_MASK & sync2);
    assign elig     = pending & mask;
    assign sel      = prio_sel(elig);
    assign bus_busy = (mem_read | mem_write) & ~mem_ok;
    assign cfg_data = {gie, mask};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            sync3     <= '0;
            edge_pend <= '0;
        end else begin
            sync1     <= pins;
            sync2     <= sync1;
            sync3     <= sync2;
            // A fresh edge wins over a clear so a re-trigger on ack is not lost.
            edge_pend <= EDGE_MASK & ((sync2 & ~sync3) | (edge_pend & ~pend_clr));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_vector <= VEC_BASE;
            isr_id     <= 2'd0;
            in_service <= 1'b0;
            gie        <= 1'b0;
            gie_saved  <= 1'b0;
            mask       <= 4'd0;
        end else begin
            state      <= state_nxt;
            irq_req    <= req_nxt;
            irq_vector <= vec_nxt;
            isr_id     <= id_nxt;
            in_service <= svc_nxt;
            gie        <= gie_nxt;
            gie_saved  <= gie_saved_nxt;
            mask       <= mask_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_nxt       = irq_req;
        vec_nxt       = irq_vector;
        id_nxt        = isr_id;
        svc_nxt       = in_service;
        gie_nxt       = cfg_write ? cfg_wdata[4] : gie;
        gie_saved_nxt = gie_saved;
        mask_nxt      = cfg_write ? cfg_wdata[3:0] : mask;
        pend_clr      = '0;

        case (state)
            IDLE: begin
                if (gie && (|elig) && !bus_busy) begin
                    state_nxt = REQ;
                    req_nxt   = 1'b1;
                    id_nxt    = sel;
                    vec_nxt   = vec_of(sel);
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_nxt        = SERVICE;
                    req_nxt          = 1'b0;
                    svc_nxt          = 1'b1;
                    // A gie write landing with the ack is what the handler returns to.
                    gie_saved_nxt    = cfg_write ? cfg_wdata[4] : gie;
                    gie_nxt          = 1'b0;
                    pend_clr[isr_id] = 1'b1;
                end else if (!(pending[isr_id] && mask[isr_id])) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            SERVICE: begin
                // gie stays off during the handler; writes go to the saved copy.
                gie_nxt = gie;
                if (cfg_write) gie_saved_nxt = cfg_wdata[4];
                if (ret) begin
                    state_nxt = IDLE;
                    svc_nxt   = 1'b0;
                    gie_nxt   = cfg_write ? cfg_wdata[4] : gie_saved;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic        int0, int1, int2, int3;
    logic        mem_read, mem_write, mem_ok;
    logic        cfg_write;
    logic [4:0]  cfg_wdata;
    logic        irq_ack, ret;

    // dut_e: all lines edge triggered; dut_l: int0 level triggered
    logic [4:0]  e_cfg_data, l_cfg_data;
    logic        e_irq_req, l_irq_req;
    logic [15:0] e_vec, l_vec;
    logic [3:0]  e_pending, l_pending;
    logic        e_in_service, l_in_service;
    logic [1:0]  e_isr_id, l_isr_id;

    int vecs = 0;
    int errs = 0;

    int_ctrl #(.VEC_BASE(16'h0004), .VEC_STRIDE(16'h0004), .EDGE_MASK(4'b1111)) dut_e (
        .clk(clk), .rst(rst), .int0(int0), .int1(int1), .int2(int2), .int3(int3),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ok(mem_ok),
        .cfg_write(cfg_write), .cfg_wdata(cfg_wdata), .cfg_data(e_cfg_data),
        .irq_req(e_irq_req), .irq_vector(e_vec), .irq_ack(irq_ack), .ret(ret),
        .pending(e_pending), .in_service(e_in_service), .isr_id(e_isr_id)
    );

    int_ctrl #(.VEC_BASE(16'h0004), .VEC_STRIDE(16'h0004), .EDGE_MASK(4'b1110)) dut_l (
        .clk(clk), .rst(rst), .int0(int0), .int1(int1), .int2(int2), .int3(int3),
        .mem_read(mem_read), .mem_write(mem_write), .mem_ok(mem_ok),
        .cfg_write(cfg_write), .cfg_wdata(cfg_wdata), .cfg_data(l_cfg_data),
        .irq_req(l_irq_req), .irq_vector(l_vec), .irq_ack(irq_ack), .ret(ret),
        .pending(l_pending), .in_service(l_in_service), .isr_id(l_isr_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; outputs are settled and inputs may change at +1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_cfg(input logic [4:0] d);
        cfg_write = 1'b1;
        cfg_wdata = d;
        tick();
        cfg_write = 1'b0;
        cfg_wdata = 5'd0;
    endtask

    task automatic do_ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_ret();
        ret = 1'b1;
        tick();
        ret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        int0 = 0; int1 = 0; int2 = 0; int3 = 0;
        mem_read = 0; mem_write = 0; mem_ok = 0;
        cfg_write = 0; cfg_wdata = 5'd0; irq_ack = 0; ret = 0;
        #1 rst = 1'b0;
        #2;
        if (e_irq_req !== 1'b0) begin $display("FAIL rst_req got=%0h exp=0", e_irq_req); errs++; end vecs++;
        if (e_vec !== 16'h0004) begin $display("FAIL rst_vec got=%04h exp=0004", e_vec); errs++; end vecs++;
        if (e_pending !== 4'd0) begin $display("FAIL rst_pend got=%0h exp=0", e_pending); errs++; end vecs++;
        if (e_in_service !== 1'b0) begin $display("FAIL rst_svc got=%0h exp=0", e_in_service); errs++; end vecs++;
        if (e_isr_id !== 2'd0) begin $display("FAIL rst_id got=%0h exp=0", e_isr_id); errs++; end vecs++;
        if (e_cfg_data !== 5'd0) begin $display("FAIL rst_cfg got=%0h exp=0", e_cfg_data); errs++; end vecs++;
        ticks(2);
        rst = 1'b1;
        tick();
    endtask

    // T1: int2 edge, four-edge latency, vector 000C, ack behaviour
    task automatic test_single_edge();
        do_cfg(5'b1_1111);
        if (e_cfg_data !== 5'b1_1111) begin $display("FAIL t1_cfg got=%0h exp=1f", e_cfg_data); errs++; end vecs++;
        int2 = 1'b1;
        tick();                                  // E1
        int2 = 1'b0;
        ticks(2);                                // E2, E3
        if (e_irq_req !== 1'b0) begin $display("FAIL t1_req_e3 got=%0h exp=0", e_irq_req); errs++; end vecs++;
        if (e_pending !== 4'b0100) begin $display("FAIL t1_pend_e3 got=%0h exp=4", e_pending); errs++; end vecs++;
        tick();                                  // E4
        if (e_irq_req !== 1'b1) begin $display("FAIL t1_req_e4 got=%0h exp=1", e_irq_req); errs++; end vecs++;
        if (e_vec !== 16'h000C) begin $display("FAIL t1_vec got=%04h exp=000c", e_vec); errs++; end vecs++;
        if (e_isr_id !== 2'd2) begin $display("FAIL t1_id got=%0h exp=2", e_isr_id); errs++; end vecs++;
        do_ack();
        if (e_irq_req !== 1'b0) begin $display("FAIL t1_ack_req got=%0h exp=0", e_irq_req); errs++; end vecs++;
        if (e_in_service !== 1'b1) begin $display("FAIL t1_ack_svc got=%0h exp=1", e_in_service); errs++; end vecs++;
        if (e_pending !== 4'd0) begin $display("FAIL t1_ack_pend got=%0h exp=0", e_pending); errs++; end vecs++;
        if (e_cfg_data !== 5'b0_1111) begin $display("FAIL t1_ack_cfg got=%0h exp=0f", e_cfg_data); errs++; end vecs++;
        do_ret();
        if (e_in_service !== 1'b0) begin $display("FAIL t1_ret_svc got=%0h exp=0", e_in_service); errs++; end vecs++;
        if (e_cfg_data !== 5'b1_1111) begin $display("FAIL t1_ret_cfg got=%0h exp=1f", e_cfg_data); errs++; end vecs++;
    endtask

    // T2: int1 and int3 together, int1 first, int3 on the edge after ret
    task automatic test_priority();
        int1 = 1'b1; int3 = 1'b1;
        tick();
        int1 = 1'b0; int3 = 1'b0;
        ticks(3);
        if (e_irq_req !== 1'b1) begin $display("FAIL t2_req got=%0h exp=1", e_irq_req); errs++; end vecs++;
        if (e_vec !== 16'h0008) begin $display("FAIL t2_vec1 got=%04h exp=0008", e_vec); errs++; end vecs++;
        if (e_pending !== 4'b1010) begin $display("FAIL t2_pend got=%0h exp=a", e_pending); errs++; end vecs++;
        do_ack();
        if (e_pending !== 4'b1000) begin $display("FAIL t2_ack_pend got=%0h exp=8", e_pending); errs++; end vecs++;
        tick();
        if (e_irq_req !== 1'b0) begin $display("FAIL t2_svc_req got=%0h exp=0", e_irq_req); errs++; end vecs++;
        do_ret();
        if (e_irq_req !== 1'b0) begin $display("FAIL t2_ret_req got=%0h exp=0", e_irq_req); errs++; end vecs++;
        tick();
        if (e_irq_req !== 1'b1) begin $display("FAIL t2_req2 got=%0h exp=1", e_irq_req); errs++; end vecs++;
        if (e_vec !== 16'h0010) begin $display("FAIL t2_vec2 got=%04h exp=0010", e_vec); errs++; end vecs++;
        if (e_isr_id !== 2'd3) begin $display("FAIL t2_id2 got=%0h exp=3", e_isr_id); errs++; end vecs++;
        do_ack();
        do_ret();
    endtask

    // T3: request held off while a read is outstanding
    task automatic test_bus_hold();
        mem_read = 1'b1; mem_ok = 1'b0;
        int0 = 1'b1;
        tick();
        int0 = 1'b0;
        ticks(3);
        if (e_pending !== 4'b0001) begin $display("FAIL t3_pend got=%0h exp=1", e_pending); errs++; end vecs++;
        for (int i = 0; i < 3; i++) begin
            if (e_irq_req !== 1'b0) begin $display("FAIL t3_hold%0d got=%0h exp=0", i, e_irq_req); errs++; end vecs++;
            tick();
        end
        if (e_irq_req !== 1'b0) begin $display("FAIL t3_hold_end got=%0h exp=0", e_irq_req); errs++; end vecs++;
        mem_ok = 1'b1;
        tick();
        mem_read = 1'b0; mem_ok = 1'b0;
        if (e_irq_req !== 1'b1) begin $display("FAIL t3_req got=%0h exp=1", e_irq_req); errs++; end vecs++;
        if (e_vec !== 16'h0004) begin $display("FAIL t3_vec got=%04h exp=0004", e_vec); errs++; end vecs++;
        do_ack();
        do_ret();
    endtask

    // T4: level int0 released in REQ (dut_l); mask withdrawal on dut_e
    task automatic test_withdraw();
        int0 = 1'b1;
        ticks(3);
        if (l_irq_req !== 1'b1) begin $display("FAIL t4_l_req got=%0h exp=1", l_irq_req); errs++; end vecs++;
        if (l_vec !== 16'h0004) begin $display("FAIL t4_l_vec got=%04h exp=0004", l_vec); errs++; end vecs++;
        if (e_irq_req !== 1'b0) begin $display("FAIL t4_e_early got=%0h exp=0", e_irq_req); errs++; end vecs++;
        tick();
        int0 = 1'b0;
        ticks(2);
        if (l_pending !== 4'd0) begin $display("FAIL t4_l_pend got=%0h exp=0", l_pending); errs++; end vecs++;
        if (l_irq_req !== 1'b1) begin $display("FAIL t4_l_hold got=%0h exp=1", l_irq_req); errs++; end vecs++;
        tick();
        if (l_irq_req !== 1'b0) begin $display("FAIL t4_l_wdraw got=%0h exp=0", l_irq_req); errs++; end vecs++;
        if (l_in_service !== 1'b0) begin $display("FAIL t4_l_svc got=%0h exp=0", l_in_service); errs++; end vecs++;
        if (e_irq_req !== 1'b1) begin $display("FAIL t4_e_req got=%0h exp=1", e_irq_req); errs++; end vecs++;
        do_cfg(5'b1_1110);
        if (e_irq_req !== 1'b1) begin $display("FAIL t4_e_mask0 got=%0h exp=1", e_irq_req); errs++; end vecs++;
        tick();
        if (e_irq_req !== 1'b0) begin $display("FAIL t4_e_wdraw got=%0h exp=0", e_irq_req); errs++; end vecs++;
        if (e_pending !== 4'b0001) begin $display("FAIL t4_e_pend got=%0h exp=1", e_pending); errs++; end vecs++;
        do_cfg(5'b1_1111);
        tick();
        if (e_irq_req !== 1'b1) begin $display("FAIL t4_e_rereq got=%0h exp=1", e_irq_req); errs++; end vecs++;
        if (e_vec !== 16'h0004) begin $display("FAIL t4_e_vec got=%04h exp=0004", e_vec); errs++; end vecs++;
        do_ack();
        do_ret();
    endtask

    // T5: re-trigger during SERVICE, gie writes deferred to ret, write with ack
    task automatic test_retrigger();
        int1 = 1'b1;
        tick();
        int1 = 1'b0;
        ticks(3);
        if (e_vec !== 16'h0008) begin $display("FAIL t5_vec got=%04h exp=0008", e_vec); errs++; end vecs++;
        do_ack();
        do_cfg(5'b1_1111);
        if (e_cfg_data !== 5'b0_1111) begin $display("FAIL t5_cfg_svc got=%0h exp=0f", e_cfg_data); errs++; end vecs++;
        int1 = 1'b1;
        tick();
        int1 = 1'b0;
        ticks(4);
        if (e_irq_req !== 1'b0) begin $display("FAIL t5_no_req got=%0h exp=0", e_irq_req); errs++; end vecs++;
        if (e_pending !== 4'b0010) begin $display("FAIL t5_pend got=%0h exp=2", e_pending); errs++; end vecs++;
        do_ret();
        if (e_cfg_data !== 5'b1_1111) begin $display("FAIL t5_ret_cfg got=%0h exp=1f", e_cfg_data); errs++; end vecs++;
        if (e_irq_req !== 1'b0) begin $display("FAIL t5_ret_req got=%0h exp=0", e_irq_req); errs++; end vecs++;
        tick();
        if (e_irq_req !== 1'b1) begin $display("FAIL t5_rereq got=%0h exp=1", e_irq_req); errs++; end vecs++;
        if (e_vec !== 16'h0008) begin $display("FAIL t5_rereq_vec got=%04h exp=0008", e_vec); errs++; end vecs++;
        // cfg write coinciding with ack: mask written now, gie deferred
        irq_ack = 1'b1; cfg_write = 1'b1; cfg_wdata = 5'b0_0111;
        tick();
        irq_ack = 1'b0; cfg_write = 1'b0; cfg_wdata = 5'd0;
        if (e_cfg_data !== 5'b0_0111) begin $display("FAIL t5_ack_cfg got=%0h exp=07", e_cfg_data); errs++; end vecs++;
        if (e_in_service !== 1'b1) begin $display("FAIL t5_ack_svc got=%0h exp=1", e_in_service); errs++; end vecs++;
        do_ret();
        if (e_cfg_data !== 5'b0_0111) begin $display("FAIL t5_ret2_cfg got=%0h exp=07", e_cfg_data); errs++; end vecs++;
        int2 = 1'b1;
        tick();
        int2 = 1'b0;
        ticks(4);
        if (e_irq_req !== 1'b0) begin $display("FAIL t5_gie0_req got=%0h exp=0", e_irq_req); errs++; end vecs++;
        if (e_pending !== 4'b0100) begin $display("FAIL t5_gie0_pend got=%0h exp=4", e_pending); errs++; end vecs++;
    endtask

    // T6: asynchronous reset while in SERVICE
    task automatic test_async_reset();
        do_cfg(5'b1_1111);
        tick();
        if (e_irq_req !== 1'b1) begin $display("FAIL t6_req got=%0h exp=1", e_irq_req); errs++; end vecs++;
        if (e_vec !== 16'h000C) begin $display("FAIL t6_vec got=%04h exp=000c", e_vec); errs++; end vecs++;
        do_ack();
        if (e_in_service !== 1'b1) begin $display("FAIL t6_svc got=%0h exp=1", e_in_service); errs++; end vecs++;
        #2 rst = 1'b0;
        #1;
        if (e_in_service !== 1'b0) begin $display("FAIL t6_rst_svc got=%0h exp=0", e_in_service); errs++; end vecs++;
        if (e_isr_id !== 2'd0) begin $display("FAIL t6_rst_id got=%0h exp=0", e_isr_id); errs++; end vecs++;
        if (e_vec !== 16'h0004) begin $display("FAIL t6_rst_vec got=%04h exp=0004", e_vec); errs++; end vecs++;
        if (e_cfg_data !== 5'd0) begin $display("FAIL t6_rst_cfg got=%0h exp=0", e_cfg_data); errs++; end vecs++;
        if (e_pending !== 4'd0) begin $display("FAIL t6_rst_pend got=%0h exp=0", e_pending); errs++; end vecs++;
        tick();
        rst = 1'b1;
        int0 = 1'b1;
        tick();
        int0 = 1'b0;
        ticks(5);
        if (e_irq_req !== 1'b0) begin $display("FAIL t6_no_req got=%0h exp=0", e_irq_req); errs++; end vecs++;
        if (e_pending !== 4'b0001) begin $display("FAIL t6_pend got=%0h exp=1", e_pending); errs++; end vecs++;
        do_cfg(5'b1_1111);
        tick();
        if (e_irq_req !== 1'b1) begin $display("FAIL t6_cfg_req got=%0h exp=1", e_irq_req); errs++; end vecs++;
        if (e_vec !== 16'h0004) begin $display("FAIL t6_cfg_vec got=%04h exp=0004", e_vec); errs++; end vecs++;
    endtask

    initial begin
        test_reset();
        test_single_edge();
        test_priority();
        test_bus_hold();
        test_withdraw();
        test_retrigger();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
